// File: rtl/iob_sync_assim_fifo_pkg.sv
// Shared definitions for the asymmetric-width FIFO.
// Provides width geometry (MIN_W, W_UNITS, R_UNITS), a clog2 helper, a
// configuration checker and a macro that stops elaboration on a bad setup.

`define IOB_ASSIM_FIFO_CHECK(W, R, A) \
  localparam bit CFG_OK = iob_assim_fifo_pkg::cfg_ok((W), (R), (A)); \
  if (!CFG_OK) begin : g_cfg_bad \
    $error("iob_assim_fifo: unsupported width ratio or capacity"); \
  end

package iob_assim_fifo_pkg;

  // Storage unit width and word sizes expressed in storage units.
  typedef struct packed {
    int unsigned min_w;
    int unsigned w_units;
    int unsigned r_units;
  } geom_t;

  function automatic geom_t fifo_geom(input int unsigned w_w, input int unsigned r_w);
    geom_t g;
    g.min_w   = (w_w < r_w) ? w_w : r_w;
    g.w_units = w_w / g.min_w;
    g.r_units = r_w / g.min_w;
    return g;
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    longint unsigned p;
    r = 0;
    p = 1;
    while (p < 64'(v)) begin
      p = p * 2;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Ratio must be a power of two and the buffer must hold two of the larger word.
  function automatic bit cfg_ok(input int unsigned w_w, input int unsigned r_w,
                                input int unsigned addr_w);
    geom_t       g;
    int unsigned max_units;
    if (w_w == 0 || r_w == 0 || addr_w == 0 || addr_w > 30) return 1'b0;
    g = fifo_geom(w_w, r_w);
    if ((w_w % g.min_w) != 0 || (r_w % g.min_w) != 0) return 1'b0;
    if (!is_pow2(g.w_units) || !is_pow2(g.r_units)) return 1'b0;
    max_units = (g.w_units > g.r_units) ? g.w_units : g.r_units;
    return (32'(1) << addr_w) >= (2 * max_units);
  endfunction

endpackage

// File: rtl/iob_sync_assim_fifo_if.sv
// Handshake bundle for iob_sync_assim_fifo.
// master: producer/consumer side (drives w_en, w_data, r_en).
// slave : FIFO side (drives full, empty, level, r_data, r_valid, error pulses).

interface iob_sync_assim_fifo_if #(
  parameter int unsigned W_DATA_W = 32,
  parameter int unsigned R_DATA_W = 8,
  parameter int unsigned ADDR_W   = 4
);
  logic                w_en;
  logic [W_DATA_W-1:0] w_data;
  logic                full;
  logic                r_en;
  logic [R_DATA_W-1:0] r_data;
  logic                r_valid;
  logic                empty;
  logic [ADDR_W:0]     level;
  logic                overflow;
  logic                underflow;

  modport master (
    output w_en, w_data, r_en,
    input  full, r_data, r_valid, empty, level, overflow, underflow
  );

  modport slave (
    input  w_en, w_data, r_en,
    output full, r_data, r_valid, empty, level, overflow, underflow
  );
endinterface

// File: rtl/iob_sync_assim_fifo_ram.sv
// Asymmetric single-clock storage built from MIN_W-wide units.
// Ports: clk, rst_n (clears only the read register), w_en/w_ptr/w_data write
// port (W_DATA_W wide), r_en/r_ptr/r_data registered read port (R_DATA_W wide).
// Pointers are in MIN_W units and naturally aligned, so the word address is
// ptr/W_UNITS (write) or ptr/R_UNITS (read) with the low bits selecting the unit.

module iob_assim_fifo_ram
  import iob_assim_fifo_pkg::*;
#(
  parameter int unsigned W_DATA_W = 32,
  parameter int unsigned R_DATA_W = 8,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                w_en,
  input  logic [ADDR_W-1:0]   w_ptr,
  input  logic [W_DATA_W-1:0] w_data,
  input  logic                r_en,
  input  logic [ADDR_W-1:0]   r_ptr,
  output logic [R_DATA_W-1:0] r_data
);
  localparam geom_t       GEOM    = fifo_geom(W_DATA_W, R_DATA_W);
  localparam int unsigned MIN_W   = GEOM.min_w;
  localparam int unsigned W_UNITS = GEOM.w_units;
  localparam int unsigned R_UNITS = GEOM.r_units;
  localparam int unsigned CAP     = 2 ** ADDR_W;

  logic [MIN_W-1:0]    mem [CAP];
  logic [R_DATA_W-1:0] rd_word;

  // Little-endian scatter of the write word; storage is never reset.
  always_ff @(posedge clk) begin
    if (w_en) begin
      for (int k = 0; k < int'(W_UNITS); k++) begin
        mem[ADDR_W'(w_ptr + ADDR_W'(k))] <= w_data[k*MIN_W +: MIN_W];
      end
    end
  end

  // Gather of the read word, low unit first.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < int'(R_UNITS); k++) begin
      rd_word[k*MIN_W +: MIN_W] = mem[ADDR_W'(r_ptr + ADDR_W'(k))];
    end
  end

  // Registered read; holds its value when no read is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (r_en) begin
      r_data <= rd_word;
    end
  end
endmodule

// File: rtl/iob_sync_assim_fifo.sv
// Single-clock width-converting FIFO.
// Ports: clk, rst_n (synchronous, active-low), bus (slave modport):
//   w_en/w_data/full write side, r_en/r_data/r_valid/empty read side,
//   level occupancy in MIN_W units, overflow/underflow one-cycle error pulses.
// Holds pointers, the level counter, flags and error pulses; data lives in
// iob_assim_fifo_ram.

module iob_sync_assim_fifo
  import iob_assim_fifo_pkg::*;
#(
  parameter int unsigned W_DATA_W = 32,
  parameter int unsigned R_DATA_W = 8,
  parameter int unsigned ADDR_W   = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  iob_sync_assim_fifo_if.slave bus
);
  localparam geom_t       GEOM    = fifo_geom(W_DATA_W, R_DATA_W);
  localparam int unsigned W_UNITS = GEOM.w_units;
  localparam int unsigned R_UNITS = GEOM.r_units;
  localparam int unsigned CAP     = 2 ** ADDR_W;
  localparam int unsigned LVL_W   = ADDR_W + 1;

  `IOB_ASSIM_FIFO_CHECK(W_DATA_W, R_DATA_W, ADDR_W)

  logic [ADDR_W-1:0]   wptr;
  logic [ADDR_W-1:0]   rptr;
  logic [LVL_W-1:0]    level;
  logic                r_valid;
  logic                overflow;
  logic                underflow;
  logic [R_DATA_W-1:0] r_data;
  logic                full_c;
  logic                empty_c;
  logic                wacc_c;
  logic                racc_c;

  // Flags come only from the registered level, so a read never sees the
  // word being written in the same cycle.
  assign full_c  = level > LVL_W'(CAP - W_UNITS);
  assign empty_c = level < LVL_W'(R_UNITS);
  assign wacc_c  = bus.w_en & ~full_c;
  assign racc_c  = bus.r_en & ~empty_c;

  // Pointer, level and pulse registers; reset wins over any request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      r_valid   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wacc_c) wptr <= ADDR_W'(wptr + ADDR_W'(W_UNITS));
      if (racc_c) rptr <= ADDR_W'(rptr + ADDR_W'(R_UNITS));
      level     <= LVL_W'(level + (wacc_c ? LVL_W'(W_UNITS) : LVL_W'(0))
                                - (racc_c ? LVL_W'(R_UNITS) : LVL_W'(0)));
      r_valid   <= racc_c;
      overflow  <= bus.w_en & full_c;
      underflow <= bus.r_en & empty_c;
    end
  end

  iob_assim_fifo_ram #(
    .W_DATA_W (W_DATA_W),
    .R_DATA_W (R_DATA_W),
    .ADDR_W   (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .w_en   (wacc_c),
    .w_ptr  (wptr),
    .w_data (bus.w_data),
    .r_en   (racc_c),
    .r_ptr  (rptr),
    .r_data (r_data)
  );

  assign bus.full      = full_c;
  assign bus.empty     = empty_c;
  assign bus.level     = level;
  assign bus.r_valid   = r_valid;
  assign bus.r_data    = r_data;
  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;
endmodule

// File: tb/tb_iob_sync_assim_fifo.sv
// Directed bench: dut_a converts 32->8, dut_b converts 8->32, both ADDR_W=4.

module tb_iob_sync_assim_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  iob_sync_assim_fifo_if #(.W_DATA_W(32), .R_DATA_W(8),  .ADDR_W(4)) bus_a ();
  iob_sync_assim_fifo_if #(.W_DATA_W(8),  .R_DATA_W(32), .ADDR_W(4)) bus_b ();

  iob_sync_assim_fifo #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_a),
    .bus   (bus_a)
  );

  iob_sync_assim_fifo #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_b),
    .bus   (bus_b)
  );

  // One clock of stimulus and the state expected right after that edge.
  typedef struct {
    bit          sel;      // 0: dut_a, 1: dut_b
    bit          rst_n;
    bit          w_en;
    logic [31:0] w_data;
    bit          r_en;
    logic [4:0]  lvl;
    bit          r_valid;
    bit          chk_data;
    logic [31:0] r_data;
    bit          ovf;
    bit          unf;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(bit sel, bit rst_n, bit w_en, logic [31:0] w_data, bit r_en,
                              int lvl, bit r_valid, bit chk_data, logic [31:0] r_data,
                              bit ovf, bit unf);
    vec_t v;
    v.sel = sel; v.rst_n = rst_n; v.w_en = w_en; v.w_data = w_data; v.r_en = r_en;
    v.lvl = 5'(lvl); v.r_valid = r_valid; v.chk_data = chk_data; v.r_data = r_data;
    v.ovf = ovf; v.unf = unf;
    tbl.push_back(v);
  endfunction

  function automatic logic [31:0] word4(int b0);
    return {8'(b0 + 3), 8'(b0 + 2), 8'(b0 + 1), 8'(b0)};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(bit sel, bit rst_n, bit w_en, logic [31:0] w_data, bit r_en);
    rst_a = sel ? 1'b1 : rst_n;
    rst_b = sel ? rst_n : 1'b1;
    bus_a.w_en   = sel ? 1'b0 : w_en;
    bus_a.r_en   = sel ? 1'b0 : r_en;
    bus_a.w_data = w_data;
    bus_b.w_en   = sel ? w_en : 1'b0;
    bus_b.r_en   = sel ? r_en : 1'b0;
    bus_b.w_data = w_data[7:0];
  endtask

  task automatic apply(int idx, vec_t v);
    logic [41:0] got;
    logic [41:0] exp;
    logic        e_empty;
    logic        e_full;
    logic [31:0] g_rd;
    drive(v.sel, v.rst_n, v.w_en, v.w_data, v.r_en);
    @(posedge clk);
    #1;
    e_empty = v.sel ? (v.lvl < 5'd4) : (v.lvl < 5'd1);
    e_full  = v.sel ? (v.lvl > 5'd15) : (v.lvl > 5'd12);
    g_rd    = v.sel ? bus_b.r_data : {24'h0, bus_a.r_data};
    if (v.sel)
      got = {bus_b.level, bus_b.empty, bus_b.full, bus_b.r_valid, bus_b.overflow,
             bus_b.underflow, v.chk_data ? g_rd : 32'h0};
    else
      got = {bus_a.level, bus_a.empty, bus_a.full, bus_a.r_valid, bus_a.overflow,
             bus_a.underflow, v.chk_data ? g_rd : 32'h0};
    exp = {v.lvl, e_empty, e_full, v.r_valid, v.ovf, v.unf, v.chk_data ? v.r_data : 32'h0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL vec%0d dut_%s got{lvl,emp,full,rv,ovf,unf,rdata}=%h exp=%h",
               idx, v.sel ? "b" : "a", got, exp);
    end
  endtask

  initial begin
    logic [7:0] abcd [4];
    abcd[0] = 8'hAA; abcd[1] = 8'hBB; abcd[2] = 8'hCC; abcd[3] = 8'hDD;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // dut_a: reset held two edges with both requests high
    for (int i = 0; i < 2; i++) add(0, 0, 1, 32'hDDCCBBAA, 1, 0, 0, 1, 32'h0, 0, 0);
    // one wide write, four narrow reads in little-endian order
    add(0, 1, 1, 32'hDDCCBBAA, 0, 4, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 1, 3 - i, 1, 1, 32'(abcd[i]), 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 1, 32'hDD, 0, 0);
    // fill to capacity, refused fifth write, then drain
    for (int i = 0; i < 4; i++) add(0, 1, 1, word4(4 * i), 0, 4 * (i + 1), 0, 0, 0, 0, 0);
    add(0, 1, 1, 32'hDEADBEEF, 0, 16, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 16, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) add(0, 1, 0, 0, 1, 15 - i, 1, 1, 32'(i), 0, 0);
    // move rptr to 12: write 8 bytes, read them back
    add(0, 1, 1, word4(8'h20), 0, 4, 0, 0, 0, 0, 0);
    add(0, 1, 1, word4(8'h24), 0, 8, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 0, 0, 1, 7 - i, 1, 1, 32'(8'h20 + i), 0, 0);
    // level 8 spanning addresses 12..15,0..3, then write+read together
    add(0, 1, 1, word4(8'h30), 0, 4, 0, 0, 0, 0, 0);
    add(0, 1, 1, word4(8'h34), 0, 8, 0, 0, 0, 0, 0);
    add(0, 1, 1, word4(8'h38), 1, 11, 1, 1, 32'h30, 0, 0);
    for (int j = 1; j < 12; j++) add(0, 1, 0, 0, 1, 11 - j, 1, 1, 32'(8'h30 + j), 0, 0);
    // read while empty: underflow, data held
    add(0, 1, 0, 0, 1, 0, 0, 1, 32'h3B, 0, 1);
    // reset in the middle of traffic
    add(0, 1, 1, word4(8'h40), 0, 4, 0, 0, 0, 0, 0);
    add(0, 1, 1, word4(8'h44), 0, 8, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 32'h0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0);

    // dut_b: reset, partial narrow fill, premature read, completing the word
    for (int i = 0; i < 2; i++) add(1, 0, 1, 32'hFF, 1, 0, 0, 1, 32'h0, 0, 0);
    add(1, 1, 1, 32'h11, 0, 1, 0, 0, 0, 0, 0);
    add(1, 1, 1, 32'h22, 0, 2, 0, 0, 0, 0, 0);
    add(1, 1, 1, 32'h33, 0, 3, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 1, 3, 0, 1, 32'h0, 0, 1);
    add(1, 1, 1, 32'h44, 0, 4, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 1, 0, 1, 1, 32'h44332211, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 1, 32'h44332211, 0, 0);

    foreach (tbl[i]) apply(i, tbl[i]);

    // dut_b: fill to full, then write+read together while full
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'(8'h50 + i), 1'b0);
      @(posedge clk);
      #1;
    end
    check("b_full_level", 32'(bus_b.level), 32'd16);
    check("b_full_flag", 32'(bus_b.full), 32'd1);
    drive(1'b1, 1'b1, 1'b1, 32'hAA, 1'b1);
    @(posedge clk);
    #1;
    check("b_full_rw_level", 32'(bus_b.level), 32'd12);
    check("b_full_rw_ovf", 32'(bus_b.overflow), 32'd1);
    check("b_full_rw_rvalid", 32'(bus_b.r_valid), 32'd1);
    check("b_full_rw_data", bus_b.r_data, 32'h53525150);
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      @(posedge clk);
      #1;
      check("b_drain_data", bus_b.r_data, word4(8'h50 + 4 * i));
      check("b_drain_ovf", 32'(bus_b.overflow), 32'd0);
    end
    check("b_drain_level", 32'(bus_b.level), 32'd0);
    check("b_drain_empty", 32'(bus_b.empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iob_sync_assim_fifo.md
Name: iob_sync_assim_fifo

Overview:
Single-clock FIFO whose write and read ports have different data widths, for example 32-bit in and 8-bit out. It is used for width conversion between IP blocks running in one clock domain.
- Data is stored and counted in units of the narrower width, MIN_W.
- Packing is little-endian: the low-order unit of a wide word goes first.
- It adds flow control (full/empty), an occupancy level, error pulses and a registered read valid.

Parameters:
W_DATA_W, 32, write data width.
R_DATA_W, 8, read data width.
ADDR_W, 4, log2 of capacity in MIN_W units; capacity CAP = 2**ADDR_W.
Derived, not overridable:
- MIN_W = min(W_DATA_W, R_DATA_W)
- W_UNITS = W_DATA_W/MIN_W
- R_UNITS = R_DATA_W/MIN_W
Constraints:
- The width ratio is a power of two.
- CAP >= 2*max(W_UNITS, R_UNITS).

Ports:
clk  in  1  clock, all logic on rising edge.
rst_n  in  1  reset, synchronous, active-low.
w_en  in  1  write request.
w_data  in  W_DATA_W  write data.
full  out  1  cannot accept a whole write word.
r_en  in  1  read request.
r_data  out  R_DATA_W  read data, registered.
r_valid  out  1  r_data updated this cycle.
empty  out  1  fewer than R_UNITS units stored.
level  out  ADDR_W+1  occupancy in MIN_W units.
overflow  out  1  one-cycle pulse: w_en while full.
underflow  out  1  one-cycle pulse: r_en while empty.

Behaviour:
- Reset (rst_n low at a clock edge):
  - level=0, write pointer=0, read pointer=0.
  - empty=1, full=0, r_valid=0, r_data=0, overflow=0, underflow=0.
  - Storage contents are not cleared.
  - Reset has priority over w_en and r_en in the same cycle, including mid-operation.
- Flags are combinational from the registered level only:
  - full = (level > CAP - W_UNITS).
  - empty = (level < R_UNITS).
- Accept rules:
  - Write accepted: wacc = w_en & ~full.
  - Read accepted: racc = r_en & ~empty.
  - Refused requests change no state other than the overflow/underflow pulse on the next cycle.
- Level update: level_next = level + W_UNITS*wacc - R_UNITS*racc. A simultaneous write and read are both honoured, each judged on its own flag.
- Pointers:
  - Both pointers are ADDR_W bits, in MIN_W units, and wrap modulo CAP.
  - wptr advances by W_UNITS; rptr advances by R_UNITS.
  - Both stay naturally aligned to their own word size.
- Packing:
  - Write: unit k of w_data (bits k*MIN_W +: MIN_W) is stored at wptr+k.
  - Read: unit k of r_data comes from rptr+k.
  - Example, 32-bit write / 8-bit read: 0xDDCCBBAA is read out as AA, BB, CC, DD.
- Read latency is 1 cycle:
  - On acceptance in cycle N, r_data is loaded at edge N+1 and r_valid=1 during cycle N+1.
  - r_data holds its value when no read is accepted.
- Write data becomes readable the cycle after acceptance. No write-to-read bypass is allowed: a word being written cannot be read in the same cycle.
- When W_DATA_W == R_DATA_W the block degenerates to a normal synchronous FIFO.

Decomposition:
Shared package iob_assim_fifo_pkg holds:
- A function returning MIN_W, W_UNITS and R_UNITS.
- A clog2 function.
- A localparam check macro for the constraints, failing elaboration on violation.

Sub-module iob_assim_fifo_ram:
- Single clock, asymmetric widths.
- Write port: W_DATA_W wide, addressed by wptr/W_UNITS.
- Read port: R_DATA_W wide, registered, addressed by rptr/R_UNITS.
- Built as an array of MIN_W units.

The top level holds the pointers, level counter, flags and error pulses.

Test Plan:
1. Reset: hold rst_n=0 for 2 edges with w_en=r_en=1 -> empty=1, full=0, level=0, r_valid=0, no overflow/underflow pulse.
2. Wide write, narrow read (32→8, ADDR_W=4):
   - Write 0xDDCCBBAA -> level=4, empty=0.
   - 4 reads -> r_data AA, BB, CC, DD, each with r_valid 1 cycle after r_en.
   - Then empty=1 and level=0.
3. Fill (32→8, ADDR_W=4):
   - 4 writes -> level=16, full=1.
   - 5th w_en -> overflow pulse for 1 cycle, level stays 16.
   - Draining 16 bytes returns the first 4 words intact.
4. Wrap with simultaneous access (32→8):
   - Preload level=8 with rptr=12.
   - Write and read in the same cycle -> write accepted, level=8+4-1=11.
   - Subsequent reads cross address 15→0 in correct byte order.
5. Narrow write, wide read (8→32, ADDR_W=4):
   - Write 0x11, 0x22, 0x33 -> empty still 1 (level=3).
   - r_en now -> underflow pulse, no r_valid.
   - Write 0x44 -> empty=0; read -> r_data=0x44332211.
6. Reset mid-operation: with level=8, assert rst_n=0 for one edge while r_en=1 -> next cycle level=0, empty=1, r_valid=0, r_data=0.
